// File: rtl/rstatus_pkg.sv
// Shared status-code definitions for the $rstatus writeback path.
package rstatus_pkg;

    typedef logic [2:0] code_t;

    localparam code_t RS_NONE = 3'd0;
    localparam code_t RS_ADD  = 3'd1;
    localparam code_t RS_ADDI = 3'd2;
    localparam code_t RS_SUB  = 3'd3;
    localparam code_t RS_MUL  = 3'd4;
    localparam code_t RS_DIV  = 3'd5;

    localparam int RSTATUS_REG = 30;

    function automatic logic code_is_alu(input code_t c);
        return (c == RS_ADD) || (c == RS_ADDI) || (c == RS_SUB);
    endfunction

    // Anything outside 1..5 is not a real status code and is dropped at entry.
    function automatic logic code_is_legal(input code_t c);
        return code_is_alu(c) || (c == RS_MUL) || (c == RS_DIV);
    endfunction

endpackage

// File: rtl/rstatus_stage.sv
// One {valid, code} pipeline register: holds on stall, flush clears valid even while stalled.
module rstatus_stage import rstatus_pkg::*; (
    input  logic  clock,
    input  logic  reset,
    input  logic  stall,
    input  logic  flush,
    input  logic  in_valid,
    input  code_t in_code,
    output logic  valid,
    output code_t code
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            code  <= RS_NONE;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!stall) begin
            valid <= in_valid;
            code  <= in_code;
        end
    end

endmodule

// File: rtl/rstatus_writeback.sv
// Carries ALU and multdiv overflow codes to the $rstatus write port, arbitrating
// collisions through two holding slots and keeping sticky flags plus a saturating count.
module rstatus_writeback #(
    parameter int CNT_W       = 8,
    parameter int RSTATUS_REG = rstatus_pkg::RSTATUS_REG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             x_ovf,
    input  logic [2:0]       x_code,
    input  logic             stall,
    input  logic             flush,
    input  logic             md_start,
    input  logic [2:0]       md_code,
    input  logic             md_ready,
    input  logic             md_exc,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             stall_req,
    output logic [4:0]       sticky,
    output logic [CNT_W-1:0] exc_count
);
    import rstatus_pkg::*;

    logic  x_entry_valid;
    logic  xm_valid, mw_valid;
    code_t xm_code, mw_code;

    assign x_entry_valid = x_valid & x_ovf & code_is_legal(x_code);

    rstatus_stage u_xm (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .flush    (flush),
        .in_valid (x_entry_valid),
        .in_code  (x_code),
        .valid    (xm_valid),
        .code     (xm_code)
    );

    rstatus_stage u_mw (
        .clock    (clock),
        .reset    (reset),
        .stall    (stall),
        .flush    (1'b0),
        .in_valid (xm_valid),
        .in_code  (xm_code),
        .valid    (mw_valid),
        .code     (mw_code)
    );

    logic  md_pend;
    code_t md_pend_code;
    logic  md_req_valid;
    code_t md_req_code;
    logic  hold_md_valid, hold_alu_valid;
    code_t hold_md_code, hold_alu_code;

    logic  alu_req;
    logic  write_valid;
    code_t write_code;
    logic  hold_md_valid_next, hold_alu_valid_next;
    code_t hold_md_code_next, hold_alu_code_next;

    assign alu_req = mw_valid & ~stall;

    // A held multdiv code is always the oldest outstanding write, so it goes first.
    always_comb begin
        write_valid         = 1'b1;
        write_code          = hold_md_code;
        hold_md_valid_next  = md_req_valid;
        hold_md_code_next   = md_req_code;
        hold_alu_valid_next = hold_alu_valid | alu_req;
        hold_alu_code_next  = hold_alu_valid ? hold_alu_code : mw_code;
        if (hold_md_valid) begin
            write_code = hold_md_code;
        end else if (hold_alu_valid) begin
            write_code          = hold_alu_code;
            hold_alu_valid_next = alu_req;
            hold_alu_code_next  = mw_code;
        end else if (md_req_valid) begin
            write_code         = md_req_code;
            hold_md_valid_next = 1'b0;
        end else if (alu_req) begin
            write_code          = mw_code;
            hold_alu_valid_next = 1'b0;
        end else begin
            write_valid = 1'b0;
        end
    end

    logic [4:0] sticky_set;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sticky
            assign sticky_set[gi] = write_valid && (write_code == code_t'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_pend        <= 1'b0;
            md_pend_code   <= RS_NONE;
            md_req_valid   <= 1'b0;
            md_req_code    <= RS_NONE;
            hold_md_valid  <= 1'b0;
            hold_md_code   <= RS_NONE;
            hold_alu_valid <= 1'b0;
            hold_alu_code  <= RS_NONE;
            wb_we          <= 1'b0;
            wb_addr        <= '0;
            wb_data        <= '0;
            stall_req      <= 1'b0;
            sticky         <= '0;
            exc_count      <= '0;
        end else begin
            // A new issue replaces any pending op; the retiring op reports its own code.
            if (md_start) begin
                md_pend      <= 1'b1;
                md_pend_code <= md_code;
            end else if (md_ready) begin
                md_pend <= 1'b0;
            end
            md_req_valid <= md_ready & md_pend & md_exc;
            md_req_code  <= md_pend_code;

            hold_md_valid  <= hold_md_valid_next;
            hold_md_code   <= hold_md_code_next;
            hold_alu_valid <= hold_alu_valid_next;
            hold_alu_code  <= hold_alu_code_next;
            stall_req      <= hold_md_valid_next | hold_alu_valid_next;

            wb_we   <= write_valid;
            wb_addr <= write_valid ? 5'(RSTATUS_REG) : 5'd0;
            wb_data <= write_valid ? {29'd0, write_code} : 32'd0;
            sticky  <= sticky | sticky_set;
            if (write_valid && (exc_count != {CNT_W{1'b1}}))
                exc_count <= exc_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rstatus_writeback.sv
// Directed and random stimulus for rstatus_writeback against a queue-based reference model.
module tb_rstatus_writeback;
    import rstatus_pkg::*;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             x_valid, x_ovf, stall, flush;
    logic [2:0]       x_code, md_code;
    logic             md_start, md_ready, md_exc;
    logic             wb_we, stall_req;
    logic [4:0]       wb_addr, sticky;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] exc_count;

    always #5 clock = ~clock;

    rstatus_writeback #(.CNT_W(CNT_W), .RSTATUS_REG(30)) dut (
        .clock     (clock),
        .reset     (reset),
        .x_valid   (x_valid),
        .x_ovf     (x_ovf),
        .x_code    (x_code),
        .stall     (stall),
        .flush     (flush),
        .md_start  (md_start),
        .md_code   (md_code),
        .md_ready  (md_ready),
        .md_exc    (md_exc),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall_req (stall_req),
        .sticky    (sticky),
        .exc_count (exc_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: two-deep execute pipeline, pending multdiv op, and a
    // FIFO of codes waiting for the single write port.
    bit         p0v, p1v, pend, mreq_v, exp_we, exp_stall_req;
    logic [2:0] p0c, p1c, pend_code, mreq_c, exp_code;
    logic [4:0] exp_sticky;
    int         exp_cnt;
    logic [2:0] wq[$];

    function automatic bit legal(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd5);
    endfunction

    task automatic model_reset();
        p0v = 0; p1v = 0; pend = 0; mreq_v = 0; exp_we = 0; exp_stall_req = 0;
        p0c = 0; p1c = 0; pend_code = 0; mreq_c = 0; exp_code = 0;
        exp_sticky = 0; exp_cnt = 0;
        wq.delete();
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (mreq_v) wq.push_back(mreq_c);
        if (!stall && p1v) wq.push_back(p1c);
        exp_we = (wq.size() > 0);
        if (exp_we) begin
            exp_code = wq.pop_front();
            if (legal(exp_code)) exp_sticky[exp_code - 3'd1] = 1'b1;
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end
        exp_stall_req = (wq.size() > 0);
        mreq_v = md_ready && pend && md_exc;
        mreq_c = pend_code;
        if (md_start) begin
            pend = 1; pend_code = md_code;
        end else if (md_ready) begin
            pend = 0;
        end
        if (!stall) begin
            p1v = p0v; p1c = p0c;
            p0v = x_valid && x_ovf && legal(x_code) && !flush;
            p0c = x_code;
        end else if (flush) begin
            p0v = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("wb_we", 32'(wb_we), 32'(exp_we));
        if (exp_we) begin
            chk("wb_data", wb_data, {29'd0, exp_code});
            chk("wb_addr", 32'(wb_addr), 32'd30);
        end
        chk("stall_req", 32'(stall_req), 32'(exp_stall_req));
        chk("sticky", 32'(sticky), 32'(exp_sticky));
        chk("exc_count", 32'(exc_count), 32'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
        check_all();
        if (wb_we) $display("cycle %0d: write r%0d code %0d count %0d", cyc, wb_addr, wb_data, exc_count);
        @(negedge clock);
    endtask

    task automatic idle();
        x_valid = 0; x_ovf = 0; x_code = 0; stall = 0; flush = 0;
        md_start = 0; md_code = 0; md_ready = 0; md_exc = 0;
    endtask

    task automatic alu(input logic [2:0] c);
        x_valid = 1; x_ovf = 1; x_code = c;
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        step();
        reset = 0;
        cyc = 0;
    endtask

    int md_timer;

    initial begin
        reset = 1;
        idle();
        model_reset();
        @(negedge clock);
        chk("reset_we", 32'(wb_we), 32'd0);
        chk("reset_addr", 32'(wb_addr), 32'd0);
        chk("reset_data", wb_data, 32'd0);
        chk("reset_stall_req", 32'(stall_req), 32'd0);
        chk("reset_sticky", 32'(sticky), 32'd0);
        chk("reset_count", 32'(exc_count), 32'd0);
        step();
        reset = 0;
        cyc = 0;

        // ALU add overflow at cycle 5 -> write at cycle 7
        repeat (4) step();
        alu(RS_ADD); step();
        idle(); step(); step();
        chk("t1_we", 32'(wb_we), 32'd1);
        chk("t1_data", wb_data, 32'd1);
        chk("t1_addr", 32'(wb_addr), 32'd30);
        chk("t1_sticky", 32'(sticky), 32'b00001);
        chk("t1_count", 32'(exc_count), 32'd1);
        step();
        chk("t1_single", 32'(wb_we), 32'd0);

        // Two stall cycles delay the write by two
        alu(RS_SUB); step();
        idle(); stall = 1; step(); step();
        chk("t2_stalled", 32'(wb_we), 32'd0);
        stall = 0; step(); step();
        chk("t2_we", 32'(wb_we), 32'd1);
        chk("t2_data", wb_data, 32'd3);

        // Flushed entry never writes, even with stall
        alu(RS_SUB); flush = 1; stall = 1; step();
        idle(); step(); step();
        chk("t2_flush", 32'(wb_we), 32'd0);
        step();

        // Multdiv div exception: start at 2, ready at 20, write at 21
        do_reset();
        step();
        md_start = 1; md_code = RS_DIV; step();
        idle(); repeat (17) step();
        md_ready = 1; md_exc = 1; step();
        idle(); step();
        chk("t3_we", 32'(wb_we), 32'd1);
        chk("t3_data", wb_data, 32'd5);
        md_start = 1; md_code = RS_MUL; step();
        idle(); repeat (3) step();
        md_ready = 1; step();
        idle(); step();
        chk("t3_noexc", 32'(wb_we), 32'd0);
        md_ready = 1; md_exc = 1; step();
        idle(); step();
        chk("t3_nopend", 32'(wb_we), 32'd0);

        // Collision: multdiv 4 then ALU 2 on consecutive cycles
        do_reset();
        md_start = 1; md_code = RS_MUL; step();
        idle(); step();
        alu(RS_ADDI); step();
        idle(); md_ready = 1; md_exc = 1; step();
        idle(); step();
        chk("t4_first", wb_data, 32'd4);
        chk("t4_stall_req", 32'(stall_req), 32'd1);
        step();
        chk("t4_second_we", 32'(wb_we), 32'd1);
        chk("t4_second", wb_data, 32'd2);
        chk("t4_stall_clr", 32'(stall_req), 32'd0);
        chk("t4_sticky", 32'(sticky), 32'b01010);
        step();

        // Asynchronous reset with a held code and a pending multdiv op
        md_start = 1; md_code = RS_MUL; step();
        idle(); step();
        alu(RS_ADDI); step();
        idle(); md_ready = 1; md_exc = 1; step();
        idle(); md_start = 1; md_code = RS_DIV; step();
        idle();
        chk("t6_held", 32'(stall_req), 32'd1);
        reset = 1;
        #1;
        chk("t6_we", 32'(wb_we), 32'd0);
        chk("t6_data", wb_data, 32'd0);
        chk("t6_addr", 32'(wb_addr), 32'd0);
        chk("t6_stall_req", 32'(stall_req), 32'd0);
        chk("t6_sticky", 32'(sticky), 32'd0);
        chk("t6_count", 32'(exc_count), 32'd0);
        step();
        reset = 0;
        md_ready = 1; md_exc = 1; step();
        idle(); repeat (4) step();
        chk("t6_quiet", 32'(exc_count), 32'd0);

        // Counter saturation after 260 back-to-back events
        for (int i = 0; i < 260; i++) begin
            alu(3'($urandom_range(1, 3)));
            step();
        end
        idle(); step(); step(); step();
        chk("t5_saturate", 32'(exc_count), 32'd255);

        // Random traffic; upstream honours stall_req
        do_reset();
        md_timer = 0;
        for (int i = 0; i < 600; i++) begin
            x_valid  = 1'($urandom_range(0, 1));
            x_ovf    = ($urandom_range(0, 3) != 0);
            x_code   = 3'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 7) == 0);
            stall    = stall_req | ($urandom_range(0, 4) == 0);
            md_start = 0; md_ready = 0; md_exc = 0;
            md_code  = 3'($urandom_range(4, 5));
            if (md_timer == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    md_start = 1;
                    md_timer = $urandom_range(4, 8);
                end else if ($urandom_range(0, 9) == 0) begin
                    md_ready = 1; md_exc = 1;
                end
            end else begin
                if (md_timer == 1) begin
                    md_ready = 1;
                    md_exc   = ($urandom_range(0, 2) != 0);
                end else if (md_timer > 2 && $urandom_range(0, 5) == 0) begin
                    md_start = 1;
                end
                md_timer--;
            end
            step();
        end
        idle(); repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rstatus_writeback.md
# rstatus_writeback

Consumer of the overflow status codes produced in execute. Carries each ALU/addi overflow code through the X/M and M/W pipeline stages and multdiv exception codes through a pending latch, then writes the 32-bit code into register $r30 ($rstatus) on a dedicated writeback port. Arbitrates simultaneous ALU and multdiv exceptions, raises a one-cycle stall when both collide, and keeps sticky per-code flags plus a saturating exception counter for debug.

## Interface
Parameters
- CNT_W, 8, width of exception counter
- RSTATUS_REG, 30, destination register index

Ports
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- x_valid  in  1  instruction in execute is valid
- x_ovf  in  1  ALU overflow detected in execute
- x_code  in  3  status code from execute: 1 add, 2 addi, 3 sub
- stall  in  1  pipeline stall; freezes X/M and M/W stage registers
- flush  in  1  kills the entry entering X/M this cycle
- md_start  in  1  multdiv operation issued this cycle
- md_code  in  3  code for issued op: 4 mul, 5 div
- md_ready  in  1  multdiv result ready (one-cycle pulse)
- md_exc  in  1  multdiv exception, valid with md_ready
- wb_we  out  1  write-enable to $r30 port
- wb_addr  out  5  always RSTATUS_REG when wb_we
- wb_data  out  32  zero-extended status code
- stall_req  out  1  request upstream stall (collision)
- sticky  out  5  bit k-1 set once code k has been written; cleared only by reset
- exc_count  out  CNT_W  number of $r30 writes, saturating

## Operation
- X/M entry loads {x_valid & x_ovf & ~flush, x_code} when ~stall; M/W entry loads from X/M when ~stall; both hold on stall.
- Codes 0, 6, 7 on x_code with x_ovf are illegal: entry loads as invalid.
- md_start latches md_code into pending register, sets md_pend. md_start while md_pend overwrites the code (newer op wins).
- md_ready & md_pend: clears md_pend; if md_exc, multdiv write request for the latched code. md_ready without md_pend ignored.
- Write select each cycle, priority: holding register, then multdiv request, then valid M/W entry (only when ~stall).
- Collision (multdiv request and valid M/W entry same cycle): multdiv written, ALU code moved to one-entry holding register, stall_req asserted that cycle; held code written next cycle.
- Held code present plus new multdiv request: held code written, multdiv code written following cycle (second holding slot for multdiv, stall_req held).
- On every write: wb_we=1, wb_addr=30, wb_data={29'b0, code}; sticky[code-1] set; exc_count increments, saturates at all-ones.

## Timing
- Reset (async assert, sync-to-clock deassert by system): all stage valids 0, md_pend 0, holding slots empty, wb_we 0, wb_addr 0, wb_data 0, stall_req 0, sticky 0, exc_count 0.
- wb_* and stall_req registered outputs.
- ALU path latency: overflow in execute at cycle N (no stall) -> wb_we high in cycle N+2 for exactly one cycle.
- Multdiv path: md_ready&md_exc at cycle M -> wb_we in cycle M+1.
- Stall delays the ALU path cycle-for-cycle; multdiv path unaffected by stall.
- flush with stall: flush wins, X/M entry invalidated.
- Reset mid-operation discards all pending/held codes; no write after reset deassert.
- At most one $r30 write per cycle.

## Structure
- Package rstatus_pkg: code constants RS_NONE=0, RS_ADD=1, RS_ADDI=2, RS_SUB=3, RS_MUL=4, RS_DIV=5; RSTATUS_REG=30; 3-bit code typedef; function code_is_alu.
- Sub-module rstatus_stage: one pipeline register {valid, code} with stall hold and flush clear; instantiated twice (X/M, M/W).

## Test plan
- Reset then x_valid=1, x_ovf=1, x_code=1 at cycle 5 -> wb_we at cycle 7, wb_addr=30, wb_data=1, sticky=5'b00001, exc_count=1.
- x_code=3 at cycle 5, stall high cycles 6-7 -> wb_we at cycle 9, wb_data=3; flush at cycle 5 instead -> no write.
- md_start code 5 cycle 2, md_ready&md_exc cycle 20 -> wb_we cycle 21, wb_data=5; md_ready without md_exc -> no write, md_pend cleared.
- Collision: ALU code 2 reaches M/W same cycle multdiv code 4 requested -> write 4 then 2 on consecutive cycles, stall_req high one cycle, sticky=5'b01010.
- 260 overflow events with CNT_W=8 -> exc_count stops at 255.
- Assert reset while holding register full and md_pend set -> outputs zero immediately, no write afterward.
